dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder serving the MEM-stage load/store port of the 5-stage core.
//  Accepts one request per handshake and models configurable access latency.
//  Performs RISC-V byte/half/word sizing with load sign/zero extension.
//  Drives mem_stall so the pipeline holds EX/MEM and the upstream stages until the response returns.
// PARAMETERS
//  ADDR_W   10  word-index width; memory depth = 2**ADDR_W 32-bit words
//  LATENCY  2   cycles from acceptance edge to response edge; legal range 1..15
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   MEM stage holds a load or store (MemRead_M | MemWrite_M)
//  req_ready   out  1   responder idle and able to accept
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   instruction funct3 (access size and signedness)
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  extended load data; valid while resp_valid=1
//  resp_err    out  1   access rejected; valid while resp_valid=1
//  mem_stall   out  1   combinational: req_valid & ~resp_valid
// BEHAVIOUR
//  Reset (reset=0, async)
//   - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; counter=0.
//   - Any in-flight request is dropped; its pending store is never written.
//   - Memory array contents are not reset.
//  FSM: IDLE -> WAIT -> DONE -> IDLE
//   - IDLE: req_ready=1. On edge with req_valid=1, latch we/funct3/addr/wdata,
//     load cnt=LATENCY-1, and go to WAIT.
//   - WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access,
//     register rdata/err, and go to DONE.
//   - DONE: resp_valid=1 for exactly one cycle. Go to IDLE unconditionally.
//     Request inputs are ignored here, since the pipeline advances on this edge.
//  Timing
//   - Accept on edge N; the array is written/read on edge N+LATENCY.
//   - resp_valid is high in the cycle after edge N+LATENCY.
//   - Back-to-back requests are spaced LATENCY+2 cycles apart.
//  Request stability
//   - Request inputs change only when req_valid=0 or resp_valid=1.
//   - Inputs are latched at acceptance; later changes do not affect the access in flight.
//  Addressing
//   - Word index = req_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
//  Loads
//   - 000 LB and 100 LBU: byte at addr[1:0], sign-/zero-extended.
//   - 001 LH and 101 LHU: half at addr[1], sign-/zero-extended.
//   - 010 LW: full word.
//  Stores (byte-enable write; unselected bytes unchanged)
//   - 000 SB: byte lane addr[1:0].
//   - 001 SH: half lane addr[1].
//   - 010 SW: all four bytes.
//  Errors
//   - Illegal funct3 (load 011/110/111, store 011-111): resp_err=1, resp_rdata=0, no write.
//   - resp_rdata=0 on every store response.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined:
//   - Halfword access with addr[0]=1 is misaligned.
//   - Word access with addr[1:0]!=0 is misaligned.
//   - Misaligned access: resp_err=1, resp_rdata=0, store suppressed.
//  DMEM_MISALIGN_CHECK_EN undefined:
//   - Offending low bits are ignored (half uses addr[1], word ignores addr[1:0]).
//   - resp_err is raised only for illegal funct3.
// TESTING
//  1. Hold reset=0 mid-WAIT of a SW -> outputs at reset values; a later LW at the same
//     address does not return the dropped store's data.
//  2. LATENCY=2: SW 0xDEADBEEF @0x10 accepted at edge N -> resp_valid high only in cycle
//     after N+2. mem_stall=1 for cycles N..N+2, then 0.
//  3. SW 0x11223344 @0x20; SB 0x80 @0x21; LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080;
//     LW @0x20 -> 0x11228044.
//  4. SH 0xF00D @0x32; LH @0x32 -> 0xFFFFF00D; LHU @0x32 -> 0x0000F00D; LW @0x30 ->
//     upper half 0xF00D, lower half unchanged.
//  5. ADDR_W=10: SW 0xCAFEF00D @0x1004; LW @0x0004 -> 0xCAFEF00D (wrap).
//     Load funct3=011 -> resp_err=1, rdata=0.
//  6. With DMEM_MISALIGN_CHECK_EN: LW @0x41 -> resp_err=1, rdata=0; SW @0x42 -> no change
//     at word 0x40. Without it: LW @0x41 returns word 0x40, resp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port, with RISC-V
// byte/half/word sizing. Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               ready_q;
  logic               resp_valid_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [31:0]        mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_data;
  logic               legal;
  logic               misalign;
  logic               err_d;
  logic [31:0]        rdata_d;
  logic               access;
  logic               mem_we;
  logic [3:0]         be;
  logic [31:0]        wdata_sh;

  // Address bits above the word index only select aliases of the same array.
  logic               unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  assign word_idx = addr_q[ADDR_W+1:2];
  assign rd_word  = mem_q[word_idx];
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && we_q && !err_d;

  always_comb begin
    rd_byte = rd_word[7:0];
    case (addr_q[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = 32'd0;
    legal     = 1'b0;
    case (funct3_q)
      3'b000: begin load_data = {{24{rd_byte[7]}}, rd_byte};  legal = 1'b1;   end
      3'b001: begin load_data = {{16{rd_half[15]}}, rd_half}; legal = 1'b1;   end
      3'b010: begin load_data = rd_word;                      legal = 1'b1;   end
      3'b100: begin load_data = {24'd0, rd_byte};             legal = !we_q;  end
      3'b101: begin load_data = {16'd0, rd_half};             legal = !we_q;  end
      default: begin load_data = 32'd0;                       legal = 1'b0;   end
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    err_d   = !legal || misalign;
    rdata_d = (err_d || we_q) ? 32'd0 : load_data;

    // Stores replicate the datum across lanes so the byte enables alone pick the target.
    be       = 4'b0000;
    wdata_sh = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_q[1:0];
        wdata_sh = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata_q[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i[ADDR_W+1:0];
            wdata_q  <= req_wdata_i;
            cnt_q    <= CntInit;
            ready_q  <= 1'b0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_stall_o  = req_valid_i && !resp_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued when a request
// is driven and compared by a monitor whenever resp_valid pulses.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  logic [31:0] mon_rd;
  logic        mon_err;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_stall_o  (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every response pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      checks++;
      if (exp_rdata_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_resp: got rdata=%h err=%b, no response was expected",
                 resp_rdata, resp_err);
      end else begin
        mon_rd  = exp_rdata_q.pop_front();
        mon_err = exp_err_q.pop_front();
        if (resp_rdata !== mon_rd || resp_err !== mon_err) begin
          errors++;
          $display("[TB] FAIL resp @%0t: got rdata=%h err=%b, want rdata=%h err=%b",
                   $time, resp_rdata, resp_err, mon_rd, mon_err);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    drive(we, f3, addr, wdata);
    exp_rdata_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 40);
    if (resp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout addr=%h: got no resp_valid in %0d cycles, want one", addr, n);
      if (exp_rdata_q.size() != 0) begin
        void'(exp_rdata_q.pop_front());
        void'(exp_err_q.pop_front());
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
        resp_err !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b stall=%b, want 1 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;

    send(1'b1, 3'b010, 32'h50, 32'hA5A5A5A5, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h50, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midwait: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 3'b010, 32'h50, 32'd0, 32'hA5A5A5A5, 1'b0);
  endtask

  task automatic test_latency();
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    exp_rdata_q.push_back(32'd0);
    exp_err_q.push_back(1'b0);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat_accept: got stall=%b ready=%b, want 1 1", mem_stall, req_ready);
    end
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (k < LAT) begin
        if (resp_valid !== 1'b0 || mem_stall !== 1'b1 || req_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL lat_wait%0d: got valid=%b stall=%b ready=%b, want 0 1 0",
                   k, resp_valid, mem_stall, req_ready);
        end
      end else begin
        if (resp_valid !== 1'b1 || mem_stall !== 1'b0) begin
          errors++;
          $display("[TB] FAIL lat_resp: got valid=%b stall=%b, want 1 0", resp_valid, mem_stall);
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat_pulse: got valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
    send(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte();
    send(1'b1, 3'b010, 32'h20, 32'h11223344, 32'd0, 1'b0);
    send(1'b1, 3'b000, 32'h21, 32'hFFFFFF80, 32'd0, 1'b0);
    send(1'b0, 3'b000, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
    send(1'b0, 3'b100, 32'h21, 32'd0, 32'h00000080, 1'b0);
    send(1'b0, 3'b010, 32'h20, 32'd0, 32'h11228044, 1'b0);
    send(1'b0, 3'b000, 32'h23, 32'd0, 32'h00000011, 1'b0);
  endtask

  task automatic test_half();
    send(1'b1, 3'b010, 32'h30, 32'h12345678, 32'd0, 1'b0);
    send(1'b1, 3'b001, 32'h32, 32'h0000F00D, 32'd0, 1'b0);
    send(1'b0, 3'b001, 32'h32, 32'd0, 32'hFFFFF00D, 1'b0);
    send(1'b0, 3'b101, 32'h32, 32'd0, 32'h0000F00D, 1'b0);
    send(1'b0, 3'b010, 32'h30, 32'd0, 32'hF00D5678, 1'b0);
    send(1'b0, 3'b001, 32'h30, 32'd0, 32'h00005678, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h20, 32'd0);
    exp_rdata_q.push_back(32'h11228044);
    exp_err_q.push_back(1'b0);
    exp_rdata_q.push_back(32'hF00D5678);
    exp_err_q.push_back(1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (resp_valid !== 1'b1 && n < 40);
    req_addr = 32'h30;
    n = 0;
    do begin @(negedge clk); n++; end while (resp_valid !== 1'b1 && n < 40);
    req_valid = 1'b0;
    checks++;
    if (n !== LAT + 2) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got %0d cycles between responses, want %0d", n, LAT + 2);
    end
  endtask

  task automatic test_wrap_err();
    send(1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, 32'd0, 1'b0);
    send(1'b0, 3'b010, 32'h0004, 32'd0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 3'b011, 32'h0004, 32'd0, 32'd0, 1'b1);
    send(1'b0, 3'b110, 32'h0004, 32'd0, 32'd0, 1'b1);
    send(1'b1, 3'b010, 32'h60, 32'h5A5A5A5A, 32'd0, 1'b0);
    send(1'b1, 3'b100, 32'h60, 32'hFFFFFFFF, 32'd0, 1'b1);
    send(1'b0, 3'b010, 32'h60, 32'd0, 32'h5A5A5A5A, 1'b0);
  endtask

  task automatic test_misalign();
    send(1'b1, 3'b010, 32'h40, 32'h0BADF00D, 32'd0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    send(1'b0, 3'b010, 32'h41, 32'd0, 32'd0, 1'b1);
    send(1'b1, 3'b010, 32'h42, 32'h77777777, 32'd0, 1'b1);
    send(1'b0, 3'b001, 32'h43, 32'd0, 32'd0, 1'b1);
    send(1'b0, 3'b010, 32'h40, 32'd0, 32'h0BADF00D, 1'b0);
`else
    send(1'b0, 3'b010, 32'h41, 32'd0, 32'h0BADF00D, 1'b0);
    send(1'b0, 3'b101, 32'h43, 32'd0, 32'h00000BAD, 1'b0);
    send(1'b1, 3'b010, 32'h42, 32'h77777777, 32'd0, 1'b0);
    send(1'b0, 3'b010, 32'h40, 32'd0, 32'h77777777, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (2) @(negedge clk);

    test_reset();
    test_latency();
    test_byte();
    test_half();
    test_back_to_back();
    test_wrap_err();
    test_misalign();

    repeat (4) @(negedge clk);
    checks++;
    if (exp_rdata_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending responses, want 0", exp_rdata_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
